// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with programmable
// wait states between request acceptance and response.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (adds resp_err, blocks misaligned
// accesses).
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | ready for a request; accepting one latches it and loads counter
// S_WAIT | counting wait states; request inputs are not sampled
// S_RESP | response presented until resp_ready; rdata held stable
//
// The memory access (store commit or load capture) happens on the edge that
// enters S_RESP. The responder enters S_RESP directly from S_IDLE when
// WAIT_CYCLES is 0, so resp_valid is first sampled high WAIT_CYCLES+1 edges
// after acceptance.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic        resp_err,
`endif
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   wr_q;
  logic [DEPTH_LOG2-1:0]  idx_q;
  logic [31:0]            wdata_q;
  logic                   mis_q;
  logic [31:0]            rdata_q, rdata_d;
  logic [31:0]            mem [DEPTH];

  logic                   accept;
  logic                   commit;
  logic                   req_mis;
  logic [DEPTH_LOG2-1:0]  req_idx;
  logic                   cm_write;
  logic                   cm_mis;
  logic [DEPTH_LOG2-1:0]  cm_idx;
  logic [31:0]            cm_wdata;
  logic                   mem_we;

  // Upper address bits fold away so addresses wrap over the array size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

  assign req_idx = req_addr[DEPTH_LOG2+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis = (req_addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign resp_rdata = rdata_q;
  assign accept     = req_valid && (state_q == S_IDLE);

  // With zero wait states the access happens on the acceptance edge, so the
  // live request fields are used instead of the latched copies.
  assign cm_write = ZERO_WAIT ? req_write : wr_q;
  assign cm_mis   = ZERO_WAIT ? req_mis   : mis_q;
  assign cm_idx   = ZERO_WAIT ? req_idx   : idx_q;
  assign cm_wdata = ZERO_WAIT ? req_wdata : wdata_q;
  assign mem_we   = commit && cm_write && !cm_mis;

  // Next-state, wait counter and commit strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cnt_d = CNT_LOAD;
          if (ZERO_WAIT) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Load data captured at commit; stores and misaligned loads return zero.
  always_comb begin
    rdata_d = rdata_q;
    if (commit) begin
      if (cm_write || cm_mis) begin
        rdata_d = 32'h0;
      end else begin
        rdata_d = mem[cm_idx];
      end
    end
  end

  // State, counter and response data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Request fields latched on acceptance; ignored at all other times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      mis_q   <= 1'b0;
    end else if (accept) begin
      wr_q    <= req_write;
      idx_q   <= req_idx;
      wdata_q <= req_wdata;
      mis_q   <= req_mis;
    end
  end

  // Storage array; deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cm_idx] <= cm_wdata;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;

  // Misalignment flag for the response in flight, qualified by S_RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= cm_mis;
    end
  end

  assign resp_err = err_q && (state_q == S_RESP);
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance a uses WAIT_CYCLES=2, instance b
// uses WAIT_CYCLES=0. Both share clock and reset.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;

  logic        a_req_valid, a_req_write, a_resp_ready;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_req_ready, a_resp_valid, a_busy;
  logic [31:0] a_resp_rdata;

  logic        b_req_valid, b_req_write, b_resp_ready;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_req_ready, b_resp_valid, b_busy;
  logic [31:0] b_resp_rdata;

`ifdef DMEM_ALIGN_CHECK_EN
  logic        a_resp_err, b_resp_err;
  logic        last_err;
`endif

  int checks;
  int failures;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (a_req_valid),
    .req_ready  (a_req_ready),
    .req_write  (a_req_write),
    .req_addr   (a_req_addr),
    .req_wdata  (a_req_wdata),
    .resp_valid (a_resp_valid),
    .resp_ready (a_resp_ready),
    .resp_rdata (a_resp_rdata),
`ifdef DMEM_ALIGN_CHECK_EN
    .resp_err   (a_resp_err),
`endif
    .busy       (a_busy)
  );

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (b_req_valid),
    .req_ready  (b_req_ready),
    .req_write  (b_req_write),
    .req_addr   (b_req_addr),
    .req_wdata  (b_req_wdata),
    .resp_valid (b_resp_valid),
    .resp_ready (b_resp_ready),
    .resp_rdata (b_resp_rdata),
`ifdef DMEM_ALIGN_CHECK_EN
    .resp_err   (b_resp_err),
`endif
    .busy       (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete transaction on instance a. lat = number of edges from the
  // acceptance edge to the first edge at which resp_valid is sampled high.
  task automatic txn_a(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat);
    int n;
    n = 0;
    while (!a_req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wd;
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_req_write = 1'b1;
    a_req_addr = 32'hFFFF_FFFC; a_req_wdata = 32'h0BAD_0BAD;
    lat = 1;
    while (!a_resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (a_resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL txn_resp_timeout addr=%h got resp_valid=%b want 1", addr, a_resp_valid);
    end
    rd = a_resp_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
    last_err = a_resp_err;
`endif
    a_resp_ready = 1'b1;
    @(posedge clk); #1;
    a_resp_ready = 1'b0;
    a_req_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks += 4;
    if (a_req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b want=1", a_req_ready); end
    if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b want=0", a_resp_valid); end
    if (a_resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_resp_rdata got=%h want=0", a_resp_rdata); end
    if (a_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", a_busy); end
    #14 rst_n = 1'b1;
    @(posedge clk); #1;
    checks += 3;
    if (a_req_ready !== 1'b1) begin failures++; $display("FAIL post_rst_req_ready got=%b want=1", a_req_ready); end
    if (b_req_ready !== 1'b1) begin failures++; $display("FAIL post_rst_b_req_ready got=%b want=1", b_req_ready); end
    if (b_busy !== 1'b0) begin failures++; $display("FAIL post_rst_b_busy got=%b want=0", b_busy); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    int lat;
    txn_a(1'b1, 32'h10, 32'hDEAD_BEEF, rd, lat);
    checks += 3;
    if (lat !== 3) begin failures++; $display("FAIL store_latency got=%0d want=3", lat); end
    if (rd !== 32'h0) begin failures++; $display("FAIL store_rdata got=%h want=0", rd); end
    if (a_req_ready !== 1'b1) begin failures++; $display("FAIL store_idle_after got=%b want=1", a_req_ready); end
    txn_a(1'b0, 32'h10, 32'h0, rd, lat);
    checks += 2;
    if (lat !== 3) begin failures++; $display("FAIL load_latency got=%0d want=3", lat); end
    if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_rdata got=%h want=deadbeef", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    int lat;
    int n;
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h10; a_req_wdata = 32'h0;
    @(posedge clk); #1;
    checks++;
    if (a_busy !== 1'b1) begin failures++; $display("FAIL bp_busy_wait got=%b want=1", a_busy); end
    // A spurious store held on the request bus must be ignored.
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h10; a_req_wdata = 32'h0;
    n = 0;
    while (!a_resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (a_resp_valid !== 1'b1) begin failures++; $display("FAIL bp_resp_valid cyc=%0d got=%b want=1", i, a_resp_valid); end
      if (a_resp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bp_rdata cyc=%0d got=%h want=deadbeef", i, a_resp_rdata); end
      if (a_req_ready !== 1'b0) begin failures++; $display("FAIL bp_req_ready cyc=%0d got=%b want=0", i, a_req_ready); end
      @(posedge clk); #1;
    end
    a_resp_ready = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_resp_ready = 1'b0;
    checks += 3;
    if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b want=0", a_resp_valid); end
    if (a_req_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b want=1", a_req_ready); end
    if (a_resp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bp_rdata_kept got=%h want=deadbeef", a_resp_rdata); end
    @(posedge clk); #1;
    checks++;
    if (a_busy !== 1'b0) begin failures++; $display("FAIL bp_no_spurious got=%b want=0", a_busy); end
    txn_a(1'b0, 32'h10, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bp_mem_intact got=%h want=deadbeef", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    int lat;
    txn_a(1'b1, 32'h1004, 32'h1234, rd, lat);
    txn_a(1'b0, 32'h0004, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h1234) begin failures++; $display("FAIL wrap_load got=%h want=1234", rd); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    int lat;
    txn_a(1'b1, 32'h20, 32'h1111_1111, rd, lat);
    txn_a(1'b0, 32'h20, 32'h0, rd, lat);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'hAAAA_5555;
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_req_write = 1'b0;
    checks++;
    if (a_busy !== 1'b1) begin failures++; $display("FAIL rmw_in_wait got=%b want=1", a_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (a_req_ready !== 1'b1) begin failures++; $display("FAIL rmw_req_ready got=%b want=1", a_req_ready); end
    if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL rmw_resp_valid got=%b want=0", a_resp_valid); end
    if (a_resp_rdata !== 32'h0) begin failures++; $display("FAIL rmw_resp_rdata got=%h want=0", a_resp_rdata); end
    if (a_busy !== 1'b0) begin failures++; $display("FAIL rmw_busy got=%b want=0", a_busy); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn_a(1'b0, 32'h20, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h1111_1111) begin failures++; $display("FAIL rmw_store_discarded got=%h want=11111111", rd); end
  endtask

  task automatic test_align();
    logic [31:0] rd;
    int lat;
    txn_a(1'b1, 32'h22, 32'hCAFE_F00D, rd, lat);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL align_store_rdata got=%h want=0", rd); end
`ifdef DMEM_ALIGN_CHECK_EN
    checks++;
    if (last_err !== 1'b1) begin failures++; $display("FAIL align_store_err got=%b want=1", last_err); end
    txn_a(1'b0, 32'h20, 32'h0, rd, lat);
    checks += 2;
    if (rd !== 32'h1111_1111) begin failures++; $display("FAIL align_prior_kept got=%h want=11111111", rd); end
    if (last_err !== 1'b0) begin failures++; $display("FAIL align_aligned_err got=%b want=0", last_err); end
    txn_a(1'b0, 32'h23, 32'h0, rd, lat);
    checks += 2;
    if (rd !== 32'h0) begin failures++; $display("FAIL align_mis_load got=%h want=0", rd); end
    if (last_err !== 1'b1) begin failures++; $display("FAIL align_mis_load_err got=%b want=1", last_err); end
`else
    txn_a(1'b0, 32'h20, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL align_off_store got=%h want=cafef00d", rd); end
`endif
  endtask

  task automatic test_back_to_back();
    logic        wr_t  [4];
    logic [31:0] ad_t  [4];
    logic [31:0] wd_t  [4];
    logic [31:0] exp_t [4];
    wr_t[0] = 1'b1; ad_t[0] = 32'h40; wd_t[0] = 32'h5A5A_0001; exp_t[0] = 32'h0;
    wr_t[1] = 1'b1; ad_t[1] = 32'h44; wd_t[1] = 32'h5A5A_0002; exp_t[1] = 32'h0;
    wr_t[2] = 1'b0; ad_t[2] = 32'h40; wd_t[2] = 32'h0;         exp_t[2] = 32'h5A5A_0001;
    wr_t[3] = 1'b0; ad_t[3] = 32'h44; wd_t[3] = 32'h0;         exp_t[3] = 32'h5A5A_0002;
    b_resp_ready = 1'b1;
    b_req_valid = 1'b1; b_req_write = wr_t[0]; b_req_addr = ad_t[0]; b_req_wdata = wd_t[0];
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (b_req_ready !== 1'b1) begin failures++; $display("FAIL b2b_accept_ready i=%0d got=%b want=1", i, b_req_ready); end
      @(posedge clk); #1;
      checks += 3;
      if (b_resp_valid !== 1'b1) begin failures++; $display("FAIL b2b_resp_valid i=%0d got=%b want=1", i, b_resp_valid); end
      if (b_req_ready !== 1'b0) begin failures++; $display("FAIL b2b_resp_ready_low i=%0d got=%b want=0", i, b_req_ready); end
      if (b_resp_rdata !== exp_t[i]) begin failures++; $display("FAIL b2b_rdata i=%0d got=%h want=%h", i, b_resp_rdata, exp_t[i]); end
      if (i < 3) begin
        b_req_write = wr_t[i+1]; b_req_addr = ad_t[i+1]; b_req_wdata = wd_t[i+1];
      end else begin
        b_req_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    b_resp_ready = 1'b0;
    checks += 2;
    if (b_resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%b want=0", b_resp_valid); end
    if (b_busy !== 1'b0) begin failures++; $display("FAIL b2b_end_busy got=%b want=0", b_busy); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 32'h0; a_req_wdata = 32'h0; a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0; b_resp_ready = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    last_err = 1'b0;
`endif
    test_reset();
    test_store_load();
    test_backpressure();
    test_wrap();
    test_reset_mid_wait();
    test_align();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
